// File: rtl/adc_spi_responder.sv
// adc_spi_responder: stand-in for an 8-channel 12-bit serial ADC. It captures config bits and shifts out channel samples.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_BITS   = 12,
  parameter int CFG_BITS    = 6
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 ADC_SCLK,
  input  logic                 ADC_CS_N,
  input  logic                 ADC_SADDR,
  output logic                 ADC_SDAT,
  input  logic [DATA_BITS-1:0] CH0,
  input  logic [DATA_BITS-1:0] CH1,
  input  logic [DATA_BITS-1:0] CH2,
  input  logic [DATA_BITS-1:0] CH3,
  input  logic [DATA_BITS-1:0] CH4,
  input  logic [DATA_BITS-1:0] CH5,
  input  logic [DATA_BITS-1:0] CH6,
  input  logic [DATA_BITS-1:0] CH7,
  output logic [CFG_BITS-1:0]  cfg_word,
  output logic                 cfg_valid,
  output logic                 cfg_err,
  output logic                 frame_abort,
  output logic [15:0]          frame_cnt
);
  localparam int CW = $clog2(DATA_BITS + 1);
  typedef enum logic [1:0] {WAIT_HI, IDLE, SHIFT, TAIL} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES:0]   sclk_q, sclk_d, cs_q, cs_d;
  logic [SYNC_STAGES-1:0] saddr_q, saddr_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [CFG_BITS-1:0]    cfg_shift_q, cfg_shift_d, cfg_word_q, cfg_word_d;
  logic [DATA_BITS-1:0]   tx_q, tx_d;
  logic [2:0]             next_ch_q, next_ch_d;
  logic                   zero_q, zero_d, sdat_q, sdat_d;
  logic                   cfg_valid_q, cfg_valid_d, cfg_err_q, cfg_err_d, abort_q, abort_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   cs_s, cs_fall, cs_rise, sclk_rise, sclk_fall, saddr_s, frame_end;
  logic [DATA_BITS-1:0]   ch [8];
  assign ch = '{CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7};
  assign cs_s      = cs_q[SYNC_STAGES-1];
  assign cs_fall   = ~cs_s & cs_q[SYNC_STAGES];
  assign cs_rise   = cs_s & ~cs_q[SYNC_STAGES];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
  assign saddr_s   = saddr_q[SYNC_STAGES-1];
  assign ADC_SDAT    = sdat_q;
  assign cfg_word    = cfg_word_q;
  assign cfg_valid   = cfg_valid_q;
  assign cfg_err     = cfg_err_q;
  assign frame_abort = abort_q;
  assign frame_cnt   = frame_cnt_q;
  // Frame sequencing: CS_N edges frame the transfer, SCLK edges move config in and sample bits out; a CS_N rise wins over a coincident SCLK edge.
  always_comb begin
    sclk_d      = {sclk_q[SYNC_STAGES-1:0], ADC_SCLK};
    cs_d        = {cs_q[SYNC_STAGES-1:0], ADC_CS_N};
    saddr_d     = SYNC_STAGES'({saddr_q, ADC_SADDR});
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cfg_shift_d = cfg_shift_q;
    tx_d        = tx_q;
    cfg_word_d  = cfg_word_q;
    next_ch_d   = next_ch_q;
    zero_d      = zero_q;
    frame_cnt_d = frame_cnt_q;
    cfg_valid_d = 1'b0;
    cfg_err_d   = 1'b0;
    abort_d     = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      WAIT_HI: state_d = cs_s ? IDLE : WAIT_HI;
      IDLE: if (cs_fall) begin
        state_d     = SHIFT;
        tx_d        = zero_q ? '0 : ch[next_ch_q];
        bit_cnt_d   = '0;
        cfg_shift_d = '0;
      end
      SHIFT: if (cs_rise) frame_end = 1'b1;
      else begin
        if (sclk_fall) tx_d = tx_q << 1;
        if (sclk_rise) begin
          if (bit_cnt_q < CW'(CFG_BITS)) cfg_shift_d = {cfg_shift_q[CFG_BITS-2:0], saddr_s};
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_d == CW'(DATA_BITS)) ? TAIL : SHIFT;
        end
      end
      default: frame_end = cs_rise;
    endcase
    if (frame_end) begin
      state_d = IDLE;
      if (bit_cnt_q >= CW'(CFG_BITS)) begin
        cfg_word_d  = cfg_shift_q;
        cfg_valid_d = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        cfg_err_d   = ~cfg_shift_q[CFG_BITS-1];
        zero_d      = ~cfg_shift_q[CFG_BITS-1];
        next_ch_d   = cfg_shift_q[CFG_BITS-1] ? {cfg_shift_q[CFG_BITS-3], cfg_shift_q[CFG_BITS-4], cfg_shift_q[CFG_BITS-2]} : next_ch_q;
      end else abort_d = 1'b1;
    end
    sdat_d = (state_d == SHIFT) & tx_d[DATA_BITS-1];
  end
  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= WAIT_HI;
      sclk_q      <= '0;
      cs_q        <= '0;
      saddr_q     <= '0;
      bit_cnt_q   <= '0;
      cfg_shift_q <= '0;
      tx_q        <= '0;
      cfg_word_q  <= '0;
      next_ch_q   <= '0;
      zero_q      <= 1'b0;
      sdat_q      <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      abort_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      saddr_q     <= saddr_d;
      bit_cnt_q   <= bit_cnt_d;
      cfg_shift_q <= cfg_shift_d;
      tx_q        <= tx_d;
      cfg_word_q  <= cfg_word_d;
      next_ch_q   <= next_ch_d;
      zero_q      <= zero_d;
      sdat_q      <= sdat_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_err_q   <= cfg_err_d;
      abort_q     <= abort_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: randomized controller-side stimulus with a frame-level reference model and queue scoreboard.
`timescale 1ns/1ps
module tb_adc_spi_responder;
  localparam int HALF = 8;
  localparam int GAP  = 12;
  logic clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs_n = 1'b1, saddr = 1'b0;
  logic sdat, cfg_valid, cfg_err, frame_abort;
  logic [5:0]  cfg_word;
  logic [15:0] frame_cnt;
  logic [11:0] ch_v [8];
  int n_cmp = 0, n_err = 0;
  logic [39:0] exp_sdat [$];
  logic [39:0] exp_evt  [$];
  int m_next = 0;
  bit m_zero = 0;
  logic [5:0]  m_cfg = '0;
  logic [15:0] m_cnt = '0;
  bit rand_ch = 0;

  adc_spi_responder dut (
    .CLOCK(clk), .RESET(rst), .ADC_SCLK(sclk), .ADC_CS_N(cs_n), .ADC_SADDR(saddr), .ADC_SDAT(sdat),
    .CH0(ch_v[0]), .CH1(ch_v[1]), .CH2(ch_v[2]), .CH3(ch_v[3]),
    .CH4(ch_v[4]), .CH5(ch_v[5]), .CH6(ch_v[6]), .CH7(ch_v[7]),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_err(cfg_err),
    .frame_abort(frame_abort), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_next = 0;
    m_zero = 0;
    m_cfg  = '0;
    m_cnt  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // One controller frame: n SCLK pulses, config bits sent MSB first, optional reset after the 7th pulse.
  task automatic frame(input logic [5:0] cfg, input int n, input bit rst_mid);
    logic [11:0] d;
    logic [31:0] w;
    d = m_zero ? 12'h000 : ch_v[m_next];
    w = '0;
    for (int i = 0; i < n; i++) w = {w[30:0], (i < 12 && !(rst_mid && i >= 7)) ? d[11-i] : 1'b0};
    exp_sdat.push_back({3'b0, 5'(n), w});
    @(negedge clk);
    cs_n  = 1'b0;
    saddr = cfg[5];
    repeat (HALF) @(negedge clk);
    if (rand_ch) for (int k = 0; k < 8; k++) ch_v[k] = 12'($urandom);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
      if (rst_mid && i == 6) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("mid_reset_cfg_word", 40'(cfg_word), 40'h0);
        chk("mid_reset_frame_cnt", 40'(frame_cnt), 40'h0);
        chk("mid_reset_sdat", 40'(sdat), 40'h0);
      end
      saddr = (i < 5) ? cfg[4-i] : 1'($urandom);
      repeat (HALF) @(negedge clk);
    end
    if (!rst_mid) begin
      if (n >= 6) begin
        m_cfg = cfg;
        m_cnt = m_cnt + 16'd1;
        if (cfg[5]) begin
          m_next = 4 * int'(cfg[3]) + 2 * int'(cfg[2]) + int'(cfg[4]);
          m_zero = 0;
        end else m_zero = 1;
        exp_evt.push_back({15'b0, 1'b1, ~cfg[5], 1'b0, m_cfg, m_cnt});
      end else exp_evt.push_back({15'b0, 3'b001, m_cfg, m_cnt});
    end
    cs_n = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  // Serial data monitor: collects bits at each pin-level SCLK rise within a frame.
  initial begin
    logic [31:0] w;
    int c;
    forever begin
      @(negedge cs_n);
      w = '0;
      c = 0;
      while (cs_n == 1'b0) begin
        @(posedge sclk or posedge cs_n);
        if (!cs_n && sclk) begin
          w = {w[30:0], sdat};
          c++;
        end
      end
      if (exp_sdat.size() == 0) chk("sdat_unexpected_frame", 40'(c), 40'hFFFF);
      else chk("sdat_frame", {3'b0, 5'(c), w}, exp_sdat.pop_front());
    end
  end

  // Status monitor: every asserted pulse cycle must match the next expected frame-end event.
  always @(negedge clk) begin
    if (!rst && (cfg_valid || cfg_err || frame_abort)) begin
      if (exp_evt.size() == 0) chk("evt_unexpected", {15'b0, cfg_valid, cfg_err, frame_abort, cfg_word, frame_cnt}, 40'hFF_FFFF_FFFF);
      else chk("evt", {15'b0, cfg_valid, cfg_err, frame_abort, cfg_word, frame_cnt}, exp_evt.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++) ch_v[k] = 12'($urandom);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_sdat", 40'(sdat), 40'h0);
    chk("reset_cfg_word", 40'(cfg_word), 40'h0);
    chk("reset_frame_cnt", 40'(frame_cnt), 40'h0);
    chk("reset_pulses", 40'({cfg_valid, cfg_err, frame_abort}), 40'h0);
    rst = 1'b0;
    repeat (GAP) @(negedge clk);
    ch_v[0] = 12'hA5C;
    frame(6'b100010, 12, 0);
    chk("first_cfg_word", 40'(cfg_word), 40'h22);
    chk("first_frame_cnt", 40'(frame_cnt), 40'h1);
    ch_v[5] = 12'h3C3;
    frame(6'b111010, 12, 0);
    frame(6'($urandom) | 6'b100000, 12, 0);
    do_reset();
    repeat (GAP) @(negedge clk);
    for (int k = 0; k < 8; k++) ch_v[k] = 12'h100 + 12'(k);
    for (int c = 0; c < 8; c++) frame({1'b1, c[0], c[2], c[1], 2'($urandom)}, 12, 0);
    chk("walk_frame_cnt", 40'(frame_cnt), 40'h8);
    frame(6'b110100, 12, 0);
    frame(6'b101100, 4, 0);
    chk("abort_frame_cnt", 40'(frame_cnt), 40'h9);
    frame(6'b000110, 16, 0);
    frame(6'b100110, 16, 0);
    frame(6'b111110, 16, 0);
    rand_ch = 1;
    frame(6'b111110, 12, 1);
    frame(6'b100110, 12, 0);
    for (int r = 0; r < 30; r++) begin
      logic [5:0] cfg;
      cfg = 6'($urandom);
      cfg[5] = ($urandom_range(0, 3) != 0);
      frame(cfg, $urandom_range(0, 16), 0);
    end
    repeat (20) @(negedge clk);
    chk("pending_events", 40'(exp_evt.size()), 40'h0);
    chk("pending_frames", 40'(exp_sdat.size()), 40'h0);
    chk("final_frame_cnt", 40'(frame_cnt), 40'(m_cnt));
    chk("final_cfg_word", 40'(cfg_word), 40'(m_cfg));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
